uart_op_tx: RTL
===============

// Module: uart_op_tx
// PURPOSE
//  Host-side UART sequencer: on one start request, serializes operand A, operand B and
//  opcode as three back-to-back UART frames (LSB first) toward the ALU TOP's serial input.
//  Contains its own baud divider; single clock domain. Used as the on-board/sim stimulus
//  source for TOP, replacing hand-timed bit toggling.
// PARAMETERS
//  DATA_WIDTH  8          bits per frame payload (A, B, opcode all DATA_WIDTH)
//  CLK_FREQ    5_000_000  i_clock frequency in Hz
//  BAUD_RATE   9600       serial bit rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division, >=2)
// PORTS
//  i_clock       in   1           system clock, rising edge
//  i_reset       in   1           asynchronous, active-low reset
//  i_start       in   1           request: send A, B, opcode (sampled only in IDLE)
//  i_data_a      in   DATA_WIDTH  operand A, latched on accepted i_start
//  i_data_b      in   DATA_WIDTH  operand B, latched on accepted i_start
//  i_opcode      in   DATA_WIDTH  opcode, latched on accepted i_start
//  o_tx          out  1           serial line, idle high
//  o_busy        out  1           high from accepted start through last stop bit
//  o_frame_done  out  1           1-cycle pulse at end of each frame's stop bit
//  o_done        out  1           1-cycle pulse at end of third frame's stop bit
// BEHAVIOUR
//  - Reset (i_reset=0, async): o_tx=1, o_busy=0, o_frame_done=0, o_done=0, state IDLE,
//    baud counter=0, bit index=0, frame index=0; takes effect mid-frame with no completion pulse.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (frame<2 ? START : IDLE).
//  - IDLE: i_start=1 at edge N latches A/B/opcode into a 3-entry shift buffer, o_busy=1
//    and o_tx=0 from edge N (registered outputs), i.e. start bit begins next cycle.
//  - Each bit held exactly BAUD_DIV clocks; baud counter restarts at every bit boundary.
//  - DATA: DATA_WIDTH bits, bit 0 first. STOP: one bit, o_tx=1.
//  - Frames are contiguous: next START follows STOP with zero idle cycles.
//  - Frame order fixed: A, B, opcode.
//  - o_frame_done pulses on the last clock of each STOP bit; on frame 2 o_done pulses the
//    same cycle, and o_busy drops the following cycle (state IDLE).
//  - i_start while o_busy=1: ignored, inputs not re-latched, no queuing.
//  - i_start held high continuously: new transfer accepted the first cycle in IDLE
//    (one-cycle minimum gap of o_tx=1 between transfers).
//  - Input changes after acceptance have no effect on the transfer in progress.
//  - Transfer length: 3*(DATA_WIDTH+2)*BAUD_DIV clocks (+3*BAUD_DIV with parity).
// CONFIGURATION
//  UART_PARITY_EN defined: PARITY state inserted after DATA; bit = odd parity
//    (~^payload, total ones incl. parity odd); frame = DATA_WIDTH+3 bits.
//  UART_PARITY_EN undefined: no PARITY state; frame = DATA_WIDTH+2 bits.
// TESTING  (bench: CLK_FREQ=16, BAUD_RATE=1 -> BAUD_DIV=16; decode o_tx mid-bit)
//  1. Reset release, no start -> o_tx=1, o_busy=0, pulses 0 for 1000 cycles.
//  2. A=0x03,B=0x82,op=0x20, 1-cycle i_start, parity off -> frames 0x03,0x82,0x20 decoded,
//     stop bits high, o_frame_done x3, o_done at cycle 480 after accept, o_busy low at 481.
//  3. Same with UART_PARITY_EN -> parity bits 1,1,0; o_done at cycle 528.
//  4. i_start re-pulsed mid-frame 1 with different data -> ignored, original bytes sent.
//  5. i_reset low during DATA of frame 1 -> o_tx=1 immediately, o_busy=0, no o_done;
//     new start after release sends full 3-frame transfer correctly.
//  6. i_start held high across two transfers (0xFF,0x00,0x55) -> exactly one idle-high
//     cycle between transfers, both decode correctly.

Source files
------------

// File: rtl/uart_op_tx.sv
// Host-side UART sequencer: sends operand A, operand B and opcode as three contiguous LSB-first frames.
// Define UART_PARITY_EN to append an odd-parity bit after each frame's payload.
module uart_op_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 5_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic [DATA_WIDTH-1:0] i_opcode,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          baud_cnt, baud_cnt_nxt;
    logic [BIT_W-1:0]          bit_idx, bit_idx_nxt;
    logic [1:0]                frame_idx, frame_idx_nxt;
    logic [3*DATA_WIDTH-1:0]   frames, frames_nxt;
    logic [DATA_WIDTH-1:0]     data_sh, data_sh_nxt, data_shr;
    logic                      tx_nxt, busy_nxt, frame_done_nxt, done_nxt;
    logic                      bit_end;

    assign bit_end  = (baud_cnt == CNT_LAST);
    assign data_shr = data_sh >> 1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            frame_idx    <= '0;
            frames       <= '0;
            data_sh      <= '0;
            o_tx         <= 1'b1;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state        <= state_nxt;
            baud_cnt     <= baud_cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            frame_idx    <= frame_idx_nxt;
            frames       <= frames_nxt;
            data_sh      <= data_sh_nxt;
            o_tx         <= tx_nxt;
            o_busy       <= busy_nxt;
            o_frame_done <= frame_done_nxt;
            o_done       <= done_nxt;
        end
    end

    // Outputs are registered: next-state logic computes the line level for the bit about to start.
    always_comb begin
        state_nxt      = state;
        baud_cnt_nxt   = baud_cnt;
        bit_idx_nxt    = bit_idx;
        frame_idx_nxt  = frame_idx;
        frames_nxt     = frames;
        data_sh_nxt    = data_sh;
        tx_nxt         = o_tx;
        busy_nxt       = o_busy;
        frame_done_nxt = 1'b0;
        done_nxt       = 1'b0;

        if (state != IDLE)
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt     = START;
                    frames_nxt    = {i_opcode, i_data_b, i_data_a};
                    frame_idx_nxt = '0;
                    bit_idx_nxt   = '0;
                    baud_cnt_nxt  = '0;
                    tx_nxt        = 1'b0;
                    busy_nxt      = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    data_sh_nxt = frames[DATA_WIDTH-1:0];
                    bit_idx_nxt = '0;
                    tx_nxt      = frames[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = ~^frames[DATA_WIDTH-1:0];
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        data_sh_nxt = data_shr;
                        tx_nxt      = data_shr[0];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                // Pulses are registered, so they are raised one clock early to land on the last stop clock.
                if (baud_cnt == CNT_PRE) begin
                    frame_done_nxt = 1'b1;
                    done_nxt       = (frame_idx == 2'd2);
                end
                if (bit_end) begin
                    if (frame_idx == 2'd2) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt     = START;
                        frame_idx_nxt = frame_idx + 1'b1;
                        frames_nxt    = frames >> DATA_WIDTH;
                        tx_nxt        = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
